// File: rtl/matrix_inv_seq_if.sv
// Handshake and data bundle for the sequential 2x2 matrix inverter.
// The master modport drives the request side and the slave modport is the inverter.
interface matrix_inv_seq_if #(
  parameter int W = 16
);
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] c;
  logic [W-1:0] d;
  logic [W-1:0] a_inv;
  logic [W-1:0] b_inv;
  logic [W-1:0] c_inv;
  logic [W-1:0] d_inv;
  logic         busy;
  logic         done;
  logic         error;
  logic         sat;

  modport master (
    output start, a, b, c, d,
    input  a_inv, b_inv, c_inv, d_inv, busy, done, error, sat
  );

  modport slave (
    input  start, a, b, c, d,
    output a_inv, b_inv, c_inv, d_inv, busy, done, error, sat
  );
endinterface

// File: rtl/matrix_inv_seq.sv
// Sequential 2x2 signed Q(W-F).F matrix inverter built around one shared restoring divider.
// Define MATRIX_INV_SAT_EN to clamp overflowing results; otherwise results wrap to W bits.
module matrix_inv_seq #(
  parameter int W = 16,
  parameter int F = 8
) (
  input logic             clk,
  input logic             reset_n,
  matrix_inv_seq_if.slave bus
);
  localparam int Q  = W + 2 * F;
  localparam int CW = $clog2(Q);

  typedef enum logic [1:0] {IDLE, DET, DIV, DONE} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   a_q, b_q, c_q, d_q;
  logic [2*W-1:0] detMag_q;
  logic           detNeg_q;
  logic [1:0]     idx_q;
  logic [CW-1:0]  cnt_q;
  logic [2*W-1:0] rem_q;
  logic [Q-2:0]   quo_q;
  logic [W-1:0]   res0_q, res1_q, res2_q;
  logic           satAcc_q;
  logic [W-1:0]   aInv_q, bInv_q, cInv_q, dInv_q;
  logic           error_q, sat_q;

  logic [2*W-1:0] det, detMag;
  logic [W:0]     xs, xMag;
  logic [Q-1:0]   num, quoNext;
  logic [2*W:0]   trial, remNext;
  logic           ge, neg, ovf;
  logic [Q:0]     sq;
  logic [W-1:0]   result;

  // Low 2W bits of the product are identical for signed and unsigned operands.
  always_comb begin
    det    = {{W{a_q[W-1]}}, a_q} * {{W{d_q[W-1]}}, d_q}
           - {{W{b_q[W-1]}}, b_q} * {{W{c_q[W-1]}}, c_q};
    detMag = det[2*W-1] ? -det : det;
  end

  // Numerators are formed at W+1 bits so that negating -2^(W-1) cannot overflow.
  always_comb begin
    case (idx_q)
      2'd0:    xs = {d_q[W-1], d_q};
      2'd1:    xs = -{b_q[W-1], b_q};
      2'd2:    xs = -{c_q[W-1], c_q};
      default: xs = {a_q[W-1], a_q};
    endcase
    xMag    = xs[W] ? -xs : xs;
    num     = Q'(xMag) << (2 * F);
    trial   = {rem_q, num[cnt_q]};
    ge      = trial >= {1'b0, detMag_q};
    remNext = ge ? trial - {1'b0, detMag_q} : trial;
    quoNext = {quo_q, ge};
    neg     = xs[W] ^ detNeg_q;
    sq      = neg ? -{1'b0, quoNext} : {1'b0, quoNext};
  end

`ifdef MATRIX_INV_SAT_EN
  localparam logic [Q-1:0] MIN_MAG = Q'(1) << (W - 1);
  localparam logic [Q-1:0] MAX_MAG = MIN_MAG - Q'(1);

  always_comb begin
    ovf    = neg ? (quoNext > MIN_MAG) : (quoNext > MAX_MAG);
    result = W'(sq);
    if (ovf) begin
      result = neg ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
  end
`else
  always_comb begin
    ovf    = 1'b0;
    result = W'(sq);
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = DET;
      DET:     state_d = (det == '0) ? DONE : DIV;
      DIV:     if (cnt_q == '0 && idx_q == 2'd3) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state_q == DET) || (state_q == DIV);
    bus.done = (state_q == DONE);
  end

  // The fourth quotient lands straight in the outputs so they are visible in the DONE cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q <= '0; b_q <= '0; c_q <= '0; d_q <= '0;
      detMag_q <= '0; detNeg_q <= 1'b0;
      idx_q <= '0; cnt_q <= '0; rem_q <= '0; quo_q <= '0;
      res0_q <= '0; res1_q <= '0; res2_q <= '0; satAcc_q <= 1'b0;
      aInv_q <= '0; bInv_q <= '0; cInv_q <= '0; dInv_q <= '0;
      error_q <= 1'b0; sat_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            a_q <= bus.a; b_q <= bus.b; c_q <= bus.c; d_q <= bus.d;
          end
        end
        DET: begin
          detMag_q <= detMag;
          detNeg_q <= det[2*W-1];
          idx_q    <= '0;
          cnt_q    <= CW'(Q - 1);
          rem_q    <= '0;
          quo_q    <= '0;
          satAcc_q <= 1'b0;
          if (det == '0) begin
            aInv_q <= '0; bInv_q <= '0; cInv_q <= '0; dInv_q <= '0;
            error_q <= 1'b1;
            sat_q   <= 1'b0;
          end
        end
        DIV: begin
          if (cnt_q == '0) begin
            rem_q    <= '0;
            quo_q    <= '0;
            cnt_q    <= CW'(Q - 1);
            idx_q    <= idx_q + 2'd1;
            satAcc_q <= satAcc_q | ovf;
            case (idx_q)
              2'd0: res0_q <= result;
              2'd1: res1_q <= result;
              2'd2: res2_q <= result;
              default: begin
                aInv_q  <= res0_q;
                bInv_q  <= res1_q;
                cInv_q  <= res2_q;
                dInv_q  <= result;
                error_q <= 1'b0;
                sat_q   <= satAcc_q | ovf;
              end
            endcase
          end else begin
            rem_q <= (2*W)'(remNext);
            quo_q <= quoNext[Q-2:0];
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.a_inv = aInv_q;
  assign bus.b_inv = bInv_q;
  assign bus.c_inv = cInv_q;
  assign bus.d_inv = dInv_q;
  assign bus.error = error_q;
  assign bus.sat   = sat_q;
endmodule

// File: doc/matrix_inv_seq.md
# matrix_inv_seq

Parametrised, sequential 2x2 signed fixed-point matrix inverter with a start/busy/done handshake, singular-matrix detection and optional output saturation. Accepts one matrix [[a,b],[c,d]] in signed Q(W-F).F format and returns its inverse in the same format, using one shared restoring divider iterated four times. Sits in the project datapath as the drop-in successor of the fixed 16-bit matrix inverter, with width and fraction generalised and a real cycle-accurate protocol.

## Interface
- W, 16: element width in bits (two's complement), W >= 4
- F, 8: fraction bits, 0 <= F <= W-2
- clk  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only in IDLE
- a, b, c, d  in  W each  signed Q(W-F).F input elements; captured on accepted start
- a_inv, b_inv, c_inv, d_inv  out  W each  signed inverse elements, registered
- busy  out  1  high from cycle after accepted start until done
- done  out  1  one-cycle pulse, results valid
- error  out  1  det == 0 for the last operation; held with results
- sat  out  1  any of the four results saturated in the last operation; held with results

## Operation
- States: IDLE, DET, DIV, DONE.
- IDLE: start=1 captures a,b,c,d into internal registers, -> DET. start while not IDLE is ignored (no queueing).
- DET: det = a*d - b*c, 2W-bit signed, exact. det == 0 -> DONE with error=1, all results 0, sat=0. Else -> DIV.
- DIV: four divides in order a_inv<-d, b_inv<-(-b), c_inv<-(-c), d_inv<-a. Each: numerator magnitude |x| << 2F (W+2F bits), divisor |det|, unsigned restoring division, one quotient bit per cycle, Q = W+2F iterations. Quotient truncated toward zero; sign = sign(x) xor sign(det). Negation of -2^(W-1) handled at W+1 bits (no overflow before division).
- Result range: positive magnitude > 2^(W-1)-1 or negative magnitude > 2^(W-1) is overflow (see Configuration).
- DONE: output registers update, done=1 for one cycle, busy=0, -> IDLE. A start in the DONE cycle is ignored.
- Outputs, error, sat hold until the next operation's DONE.
- Reset (any time, incl. mid-operation): state IDLE; a_inv..d_inv=0, busy=0, done=0, error=0, sat=0; operation discarded.

## Timing
- Cycle 0: start sampled high in IDLE. Cycle 1: DET, busy=1.
- Non-singular: divides occupy cycles 2 .. 4Q+1; done=1 and new results visible in cycle 4Q+2. W=16, F=8: Q=32, done at cycle 130.
- Singular: done=1, error=1 in cycle 2.
- busy=1 exactly in cycles 1 .. (done cycle - 1); done and busy never both high.
- Minimum start-to-start spacing: latency + 1 cycle (next start accepted in the cycle after done).

## Configuration
- MATRIX_INV_SAT_EN defined: overflowing results clamp to 2^(W-1)-1 or -2^(W-1); sat=1 if any clamp occurred in the operation.
- Undefined: results are the low W bits of the signed quotient (wrap-around); sat tied to 0.

## Test plan
- Identity, W=16 F=8: a=256,b=0,c=0,d=256, start -> done at cycle 130, a_inv=256, b_inv=0, c_inv=0, d_inv=256, error=0, sat=0.
- Diagonal: a=512, d=1024, b=c=0 -> det=524288; a_inv=128, d_inv=64, b_inv=c_inv=0.
- Negative det: a=0,b=256,c=256,d=0 -> det=-65536; a_inv=0, b_inv=256, c_inv=256, d_inv=0.
- Singular: a=256,b=512,c=128,d=256 -> done at cycle 2, error=1, all outputs 0, busy high only in cycle 1.
- Overflow: a=1,d=1,b=c=0 -> a_inv=d_inv=32767, sat=1 with MATRIX_INV_SAT_EN; a_inv=d_inv=0, sat=0 without.
- Protocol: start re-asserted during busy and in done cycle -> ignored, single done; reset_n low at cycle 50 -> all outputs 0, IDLE, no done; next start completes normally.
